cmd_parser: RTL



---
 rtl/cmd_pkg.sv | 37 +++
 rtl/cmd_parser_if.sv | 26 ++
 rtl/vlq_decoder.sv | 47 ++++
 rtl/cmd_parser.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - command ids, argument-count table and parser states
package cmd_pkg;

  localparam logic [3:0] NARGS_UNKNOWN = 4'hF;

  localparam logic [31:0] CMD_SET_DIGITAL_OUT      = 32'd1;
  localparam logic [31:0] CMD_CONFIG_DIGITAL_OUT   = 32'd2;
  localparam logic [31:0] CMD_SCHEDULE_DIGITAL_OUT = 32'd3;
  localparam logic [31:0] CMD_UPDATE_DIGITAL_OUT   = 32'd4;
  localparam logic [31:0] CMD_QUEUE_STEP           = 32'd5;
  localparam logic [31:0] CMD_SET_NEXT_STEP_DIR    = 32'd6;
  localparam logic [31:0] CMD_GET_CLOCK            = 32'd7;
  localparam logic [31:0] CMD_RESET_STEP_CLOCK     = 32'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARGS,
    S_PRESENT,
    S_SKIP
  } state_t;

  function automatic logic [3:0] cmd_nargs(input logic [31:0] id);
    case (id)
      CMD_SET_DIGITAL_OUT:      cmd_nargs = 4'd2;
      CMD_CONFIG_DIGITAL_OUT:   cmd_nargs = 4'd4;
      CMD_SCHEDULE_DIGITAL_OUT: cmd_nargs = 4'd3;
      CMD_UPDATE_DIGITAL_OUT:   cmd_nargs = 4'd2;
      CMD_QUEUE_STEP:           cmd_nargs = 4'd3;
      CMD_SET_NEXT_STEP_DIR:    cmd_nargs = 4'd2;
      CMD_GET_CLOCK:            cmd_nargs = 4'd0;
      CMD_RESET_STEP_CLOCK:     cmd_nargs = 4'd2;
      default:                  cmd_nargs = NARGS_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// rtl/cmd_parser_if.sv - payload byte stream in, decoded command/argument bus out
// master is the parser; slave is the framing layer plus command consumers.
interface cmd_parser_if #(parameter int CMD_BITS = 8) ();

  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_end;
  logic                in_ready;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                cmd_done;
  logic                parse_error;

  modport master (
    input  in_data, in_valid, in_end, arg_advance, cmd_done,
    output in_ready, cmd, cmd_ready, arg_data, parse_error
  );

  modport slave (
    output in_data, in_valid, in_end, arg_advance, cmd_done,
    input  in_ready, cmd, cmd_ready, arg_data, parse_error
  );

endinterface

// File: rtl/vlq_decoder.sv
// rtl/vlq_decoder.sv - Klipper VLQ integer decoder, one byte per valid cycle
// o_value is combinational so the terminating byte's value is usable in the same cycle.
module vlq_decoder #(
  parameter int MAX_VLQ_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_start,
  output logic [31:0] o_value,
  output logic        o_value_valid,
  output logic        o_overlong_err
);

  localparam int CW = $clog2(MAX_VLQ_BYTES + 2);

  logic [24:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;

  always_comb begin
    o_value = 32'd0;
    w_cnt   = CW'(1);
    if (i_start) begin
      o_value = {25'd0, i_byte[6:0]};
      if (i_byte[6:5] == 2'b11) o_value = o_value | 32'hFFFF_FFE0;
    end else begin
      o_value = {r_acc, i_byte[6:0]};
      w_cnt   = r_cnt + CW'(1);
    end
  end

  assign o_overlong_err = i_valid && (w_cnt > CW'(MAX_VLQ_BYTES));
  assign o_value_valid  = i_valid && !i_byte[7] && !o_overlong_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_valid) begin
      r_acc <= o_value[24:0];
      r_cnt <= w_cnt;
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - decodes VLQ command id + args and presents them on the cmd/arg bus
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int CMD_BITS      = 8,
  parameter int MAX_ARGS      = 8,
  parameter int MAX_VLQ_BYTES = 5
) (
  input logic          clk,
  input logic          rst_n,
  cmd_parser_if.master bus
);

  localparam int         AW    = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;
  localparam logic [3:0] MAX_N = 4'(MAX_ARGS);

  state_t              r_state, w_state_nx;
  logic [3:0]          r_nargs, w_nargs_nx;
  logic [3:0]          r_wr, w_wr_nx;
  logic [3:0]          r_rd, w_rd_nx;
  logic [CMD_BITS-1:0] r_cmd, w_cmd_nx;
  logic                r_present, w_present_nx;
  logic                r_mid, w_mid_nx;
  logic                r_perr, w_err;
  logic [31:0]         r_buf [MAX_ARGS];
  logic                w_buf_we;

  logic                w_accept;
  logic                w_dec_valid;
  logic [31:0]         w_value;
  logic                w_value_valid;
  logic                w_overlong;
  logic [3:0]          w_lookup;

  assign bus.in_ready = (r_state == S_CMD) || (r_state == S_ARGS) || (r_state == S_SKIP);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_dec_valid  = w_accept && ((r_state == S_CMD) || (r_state == S_ARGS));

  vlq_decoder #(.MAX_VLQ_BYTES(MAX_VLQ_BYTES)) u_vlq (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_byte         (bus.in_data),
    .i_valid        (w_dec_valid),
    .i_start        (!r_mid),
    .o_value        (w_value),
    .o_value_valid  (w_value_valid),
    .o_overlong_err (w_overlong)
  );

  assign w_lookup = cmd_nargs(32'(w_value[CMD_BITS-1:0]));

  always_comb begin
    w_state_nx   = r_state;
    w_nargs_nx   = r_nargs;
    w_wr_nx      = r_wr;
    w_rd_nx      = r_rd;
    w_cmd_nx     = r_cmd;
    w_present_nx = r_present;
    w_mid_nx     = r_mid;
    w_err        = 1'b0;
    w_buf_we     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nx = S_CMD;
      S_CMD, S_ARGS: begin
        if (w_dec_valid) begin
          w_mid_nx = 1'b0;
          if (w_overlong || (bus.in_data[7] && bus.in_end)) begin
            w_err = 1'b1;
          end else if (!w_value_valid) begin
            w_mid_nx = 1'b1;
          end else if (r_state == S_CMD) begin
            w_cmd_nx = w_value[CMD_BITS-1:0];
            if (w_lookup == NARGS_UNKNOWN || w_lookup > MAX_N) begin
              w_err = 1'b1;
            end else if (w_lookup == 4'd0) begin
              w_nargs_nx   = 4'd0;
              w_rd_nx      = 4'd0;
              w_present_nx = 1'b1;
              w_state_nx   = S_PRESENT;
            end else if (bus.in_end) begin
              w_err = 1'b1;
            end else begin
              w_nargs_nx = w_lookup;
              w_wr_nx    = 4'd0;
              w_state_nx = S_ARGS;
            end
          end else begin
            w_buf_we = 1'b1;
            w_wr_nx  = r_wr + 4'd1;
            if (r_wr + 4'd1 == r_nargs) begin
              w_rd_nx      = 4'd0;
              w_present_nx = 1'b1;
              w_state_nx   = S_PRESENT;
            end else if (bus.in_end) begin
              w_err = 1'b1;
            end
          end
          // An error on the message's last byte must not swallow the next message.
          if (w_err) begin
            w_wr_nx    = 4'd0;
            w_state_nx = bus.in_end ? S_CMD : S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (w_accept && bus.in_end) w_state_nx = S_CMD;
      end
      S_PRESENT: begin
        if (bus.arg_advance && bus.cmd_ready && (r_rd < r_nargs)) w_rd_nx = r_rd + 4'd1;
        if (bus.cmd_done) begin
          w_present_nx = 1'b0;
          w_rd_nx      = 4'd0;
          w_wr_nx      = 4'd0;
          w_state_nx   = S_CMD;
        end
      end
      default: w_state_nx = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_nargs   <= 4'd0;
      r_wr      <= 4'd0;
      r_rd      <= 4'd0;
      r_cmd     <= '0;
      r_present <= 1'b0;
      r_mid     <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_nargs   <= w_nargs_nx;
      r_wr      <= w_wr_nx;
      r_rd      <= w_rd_nx;
      r_cmd     <= w_cmd_nx;
      r_present <= w_present_nx;
      r_mid     <= w_mid_nx;
      r_perr    <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_wr[AW-1:0]] <= w_value;
  end

  assign bus.cmd         = r_cmd;
  assign bus.cmd_ready   = r_present && !bus.cmd_done;
  assign bus.arg_data    = (r_present && (r_rd < r_nargs)) ? r_buf[r_rd[AW-1:0]] : 32'd0;
  assign bus.parse_error = r_perr;

endmodule
